// File: rtl/adat_tx_multi.sv
// adat_tx_multi: serialises NUM_STREAMS eight-channel ADAT streams from one
// shared, one-frame-deep holding buffer. All streams share the bit timing, so
// their NRZI outputs are bit-aligned. frame_start_o marks the bit-0 slot.
// Build option: define ADAT_TX_UNDERRUN_HOLD_EN to repeat the last frame on an
// underrun; without it an underrun frame carries silence and zero user bits.
module adat_tx_multi #(
    parameter int NUM_STREAMS = 2,
    parameter int SAMPLE_W    = 24,
    parameter int CLK_DIV     = 2,
    parameter int UCNT_W      = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              s_valid_i,
    output logic                              s_ready_o,
    input  logic [NUM_STREAMS*8*SAMPLE_W-1:0] samples_i,
    input  logic [NUM_STREAMS*4-1:0]          user_i,
    output logic [NUM_STREAMS-1:0]            adat_o,
    output logic                              frame_start_o,
    output logic [UCNT_W-1:0]                 underrun_cnt_o
);

    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRAME_SMP_W = 8 * SAMPLE_W;
    localparam int ALL_SMP_W   = NUM_STREAMS * FRAME_SMP_W;

    logic [DIV_W-1:0]         div_cnt;
    logic [7:0]               bit_cnt;
    logic                     bit_ce;
    logic                     boundary;
    logic                     full;
    logic [ALL_SMP_W-1:0]     hold_smp;
    logic [NUM_STREAMS*4-1:0] hold_usr;
    logic [ALL_SMP_W-1:0]     cur_smp;
    logic [NUM_STREAMS*4-1:0] cur_usr;

    // Expand one stream's samples and user nibble into the 256-bit NRZ frame.
    // Frame bit n lives at vector index 255-n so the frame reads MSB first.
    function automatic logic [255:0] build_frame(input logic [FRAME_SMP_W-1:0] smp,
                                                 input logic [3:0]             usr);
        logic [255:0] f;
        logic [23:0]  slot;
        int           pos;
        f          = '0;
        f[245]     = 1'b1;           // bit 10: end of sync run
        f[244:241] = usr;            // bits 11-14: user nibble
        for (int ch = 0; ch < 8; ch++) begin
            // Narrow samples are left-justified into the 24-bit slot.
            slot                 = '0;
            slot[23 -: SAMPLE_W] = smp[ch*SAMPLE_W +: SAMPLE_W];
            for (int g = 0; g < 6; g++) begin
                pos              = 15 + ch*30 + g*5;
                f[255-pos]       = 1'b1;
                f[254-pos -: 4]  = slot[23-4*g -: 4];
            end
        end
        f[0] = 1'b1;                 // bit 255: trailing separator
        return f;
    endfunction

    assign bit_ce         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign boundary       = bit_ce && (bit_cnt == 8'd255);
    assign frame_start_o  = bit_ce && (bit_cnt == 8'd0);
    assign s_ready_o      = !full;

    // Bit-rate divider and frame bit position.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (bit_ce) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 8'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Holding-buffer occupancy: drained at the frame boundary, filled on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full <= 1'b0;
        end else if (boundary && full) begin
            full <= 1'b0;
        end else if (s_valid_i && !full) begin
            full <= 1'b1;
        end
    end

    // Holding-buffer payload; its contents only matter while full is set.
    always_ff @(posedge clk_i) begin
        if (s_valid_i && !full) begin
            hold_smp <= samples_i;
            hold_usr <= user_i;
        end
    end

    // Frame being emitted: reloaded at each boundary from the buffer or the underrun policy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_smp <= '0;
            cur_usr <= '0;
        end else if (boundary) begin
            if (full) begin
                cur_smp <= hold_smp;
                cur_usr <= hold_usr;
            end else begin
`ifdef ADAT_TX_UNDERRUN_HOLD_EN
                cur_smp <= cur_smp;
                cur_usr <= cur_usr;
`else
                cur_smp <= '0;
                cur_usr <= '0;
`endif
            end
        end
    end

    // Saturating count of boundaries that found the buffer empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_cnt_o <= '0;
        end else if (boundary && !full && (underrun_cnt_o != {UCNT_W{1'b1}})) begin
            underrun_cnt_o <= underrun_cnt_o + UCNT_W'(1);
        end
    end

    for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_stream
        logic [255:0] frame_bits;
        logic         nrz;
        logic         line_q;

        // NRZ frame image for this stream.
        always_comb begin
            frame_bits = build_frame(cur_smp[s*FRAME_SMP_W +: FRAME_SMP_W], cur_usr[s*4 +: 4]);
        end

        assign nrz       = frame_bits[8'd255 - bit_cnt];
        assign adat_o[s] = line_q;

        // NRZI line: a '1' bit toggles the line, a '0' bit holds it.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                line_q <= 1'b0;
            end else if (bit_ce && nrz) begin
                line_q <= ~line_q;
            end
        end
    end

endmodule
